// File: rtl/bcd_uart_pkg.sv
// Purpose: shared constants and FSM state type for the BCD-to-UART logger.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_uart_pkg;

    localparam logic [7:0] CHAR_MINUS = 8'h2D;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;
    localparam logic [7:0] CHAR_ERR   = 8'h3F;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;

    // Sign, six digits, CR, LF.
    localparam int MSG_LEN = 9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/bcd_uart_tx_bcd_to_ascii.sv
// Purpose: map one BCD digit to its ASCII character; non-decimal codes become '?'.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the input.
module bcd_to_ascii
    import bcd_uart_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] ch
);

    // Codes 10..15 cannot come from a healthy encoder; flag them visibly on the host.
    always_comb begin
        if (digit > 4'd9) begin
            ch = CHAR_ERR;
        end else begin
            ch = CHAR_ZERO + {4'h0, digit};
        end
    end

endmodule

// File: rtl/bcd_uart_tx.sv
// Purpose: serialise a signed 6-digit BCD reading as a 9-char ASCII line over 8N1 UART.
// Latency: tx start bit begins the cycle after an accepted start; message lasts 90*CLKS_PER_BIT.
// Backpressure: start is ignored (not queued) while busy; accepted again in the done cycle.
module bcd_uart_tx
    import bcd_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sign,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] digit4,
    input  logic [3:0] digit5,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    CHAR_LAST = 4'(MSG_LEN - 1);

    tx_state_t       state, state_n;
    logic [CW-1:0]   baud_cnt, baud_cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [3:0]      char_idx, char_idx_n;
    logic            tx_n, busy_n, done_n;
    logic            capture;

    // Snapshot of the reading, taken when a message is accepted.
    logic            sign_q;
    logic [5:0][3:0] dig_q;

    logic [3:0]      dig_sel;
    logic [7:0]      dig_char;
    logic [7:0]      cur_char;
    logic            baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);

    // Pick the digit addressed by the character index (char 1 = most significant).
    always_comb begin
        dig_sel = 4'h0;
        case (char_idx)
            4'd1:    dig_sel = dig_q[5];
            4'd2:    dig_sel = dig_q[4];
            4'd3:    dig_sel = dig_q[3];
            4'd4:    dig_sel = dig_q[2];
            4'd5:    dig_sel = dig_q[1];
            4'd6:    dig_sel = dig_q[0];
            default: dig_sel = 4'h0;
        endcase
    end

    bcd_to_ascii u_bcd_to_ascii (
        .digit (dig_sel),
        .ch    (dig_char)
    );

    // Character multiplexer: message position -> byte on the wire.
    always_comb begin
        cur_char = CHAR_LF;
        case (char_idx)
            4'd0:    cur_char = sign_q ? CHAR_MINUS : CHAR_SPACE;
            4'd7:    cur_char = CHAR_CR;
            4'd8:    cur_char = CHAR_LF;
            default: cur_char = dig_char;
        endcase
    end

    // Serialiser next-state logic; tx/busy/done are registered from the next state.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        char_idx_n = char_idx;
        done_n     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = START_BIT;
                    baud_cnt_n = '0;
                    char_idx_n = 4'd0;
                    capture    = 1'b1;
                end
            end
            START_BIT: begin
                baud_cnt_n = baud_last ? '0 : baud_cnt + CW'(1);
                if (baud_last) begin
                    state_n   = DATA_BITS;
                    bit_idx_n = 3'd0;
                end
            end
            DATA_BITS: begin
                baud_cnt_n = baud_last ? '0 : baud_cnt + CW'(1);
                if (baud_last) begin
                    if (bit_idx == 3'd7) begin
                        state_n = STOP_BIT;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP_BIT: begin
                baud_cnt_n = baud_last ? '0 : baud_cnt + CW'(1);
                if (baud_last) begin
                    if (char_idx < CHAR_LAST) begin
                        state_n    = START_BIT;
                        char_idx_n = char_idx + 4'd1;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Data bits go out LSB first; the char index never changes on entry to DATA_BITS.
        case (state_n)
            START_BIT: tx_n = 1'b0;
            DATA_BITS: tx_n = cur_char[bit_idx_n];
            default:   tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
    end

    // State, counters and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            char_idx <= 4'd0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            char_idx <= char_idx_n;
            tx       <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Reading snapshot so the encoder may move on during transmission.
    always_ff @(posedge clk) begin
        if (reset) begin
            sign_q <= 1'b0;
            dig_q  <= '0;
        end else if (capture) begin
            sign_q <= sign;
            dig_q  <= {digit5, digit4, digit3, digit2, digit1, digit0};
        end
    end

endmodule

// File: tb/tb_bcd_uart_tx.sv
// Purpose: self-checking bench for bcd_uart_tx using table-driven messages plus corner sequences.
// Latency: checks start-bit-next-cycle, 360-cycle busy window and single done pulse.
// Backpressure: checks that start during busy is dropped and start in the done cycle restarts.
module tb_bcd_uart_tx;

    localparam int CPB     = 4;
    localparam int MSG_CYC = 90 * CPB;

    logic       clk;
    logic       reset;
    logic       start;
    logic       sign;
    logic [3:0] digit0, digit1, digit2, digit3, digit4, digit5;
    logic       tx, busy, done;

    int n_cmp;
    int n_err;

    logic tx_s   [MSG_CYC];
    logic busy_s [MSG_CYC];
    logic done_s [MSG_CYC];

    typedef struct {
        logic        sgn;
        logic [23:0] digs;     // digit5 in [23:20] .. digit0 in [3:0]
        logic [71:0] exp;      // first transmitted byte in [71:64]
        bit          mutate;   // change inputs 20 cycles into the message
        bit          pulse;    // extra start pulse mid-message
    } vec_t;

    vec_t vecs [4];

    bcd_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .sign   (sign),
        .digit0 (digit0),
        .digit1 (digit1),
        .digit2 (digit2),
        .digit3 (digit3),
        .digit4 (digit4),
        .digit5 (digit5),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input logic sgn, input logic [23:0] digs);
        sign   = sgn;
        digit5 = digs[23:20];
        digit4 = digs[19:16];
        digit3 = digs[15:12];
        digit2 = digs[11:8];
        digit1 = digs[7:4];
        digit0 = digs[3:0];
    endtask

    // Present a reading and a start request; returns at cycle 0 of the message.
    task automatic start_msg(input logic sgn, input logic [23:0] digs, input bit hold);
        set_inputs(sgn, digs);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
    endtask

    // Record the whole message window, then check the done cycle.
    task automatic capture(input string tag, input bit mutate, input bit pulse);
        for (int i = 0; i < MSG_CYC; i++) begin
            if (i > 0) tick();
            if (mutate && i == 20) set_inputs(~sign, 24'h987654);
            if (pulse && i == 50) start = 1'b1;
            if (pulse && i == 51) start = 1'b0;
            tx_s[i]   = tx;
            busy_s[i] = busy;
            done_s[i] = done;
        end
        tick();
        check({tag, ".done_pulse"}, 72'(done), 72'd1);
        check({tag, ".done_busy"},  72'(busy), 72'd0);
        check({tag, ".done_tx"},    72'(tx),   72'd1);
    endtask

    // Decode the recorded waveform and compare against the expected bytes.
    task automatic verify(input string tag, input logic [71:0] exp);
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < MSG_CYC; i++) begin
            if (busy_s[i] === 1'b1) busy_cnt++;
            if (done_s[i] !== 1'b0) done_cnt++;
        end
        check({tag, ".busy_cycles"}, 72'(busy_cnt), 72'(MSG_CYC));
        check({tag, ".done_in_msg"}, 72'(done_cnt), 72'd0);
        for (int c = 0; c < 9; c++) begin
            logic [7:0] eb;
            logic [9:0] frame;
            logic [7:0] got;
            int         bad;
            eb    = exp[71 - 8*c -: 8];
            frame = {1'b1, eb, 1'b0};
            bad   = 0;
            for (int j = 0; j < 10; j++)
                for (int k = 0; k < CPB; k++)
                    if (tx_s[c*10*CPB + j*CPB + k] !== frame[j]) bad++;
            for (int b = 0; b < 8; b++)
                got[b] = tx_s[c*10*CPB + (b+1)*CPB + CPB/2];
            check($sformatf("%s.byte%0d", tag, c), 72'(got), 72'(eb));
            check($sformatf("%s.frame%0d_bad_samples", tag, c), 72'(bad), 72'd0);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        set_inputs(1'b0, 24'h000000);

        vecs[0] = '{1'b1, 24'h123456, 72'h2D_31_32_33_34_35_36_0D_0A, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 24'h000000, 72'h20_30_30_30_30_30_30_0D_0A, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 24'h99999C, 72'h20_39_39_39_39_39_3F_0D_0A, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 24'hA0F789, 72'h2D_3F_30_3F_37_38_39_0D_0A, 1'b0, 1'b1};

        // Reset values, then a quiet idle line.
        repeat (3) tick();
        check("rst.tx",   72'(tx),   72'd1);
        check("rst.busy", 72'(busy), 72'd0);
        check("rst.done", 72'(done), 72'd0);
        reset = 1'b0;
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 50; i++) begin
                tick();
                if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
            end
            check("idle50.bad_cycles", 72'(bad), 72'd0);
        end

        // Table-driven messages.
        for (int v = 0; v < 4; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            start_msg(vecs[v].sgn, vecs[v].digs, 1'b0);
            check({tag, ".first_tx"},   72'(tx),   72'd0);
            check({tag, ".first_busy"}, 72'(busy), 72'd1);
            capture(tag, vecs[v].mutate, vecs[v].pulse);
            verify(tag, vecs[v].exp);
            tick();
            check({tag, ".after_done"}, 72'(done), 72'd0);
            check({tag, ".after_busy"}, 72'(busy), 72'd0);
            tick();
        end

        // start held high: restart in the cycle right after done, no queued extras.
        start_msg(vecs[0].sgn, vecs[0].digs, 1'b1);
        capture("hold1", 1'b0, 1'b0);
        verify("hold1", vecs[0].exp);
        tick();
        check("hold.restart_busy", 72'(busy), 72'd1);
        check("hold.restart_tx",   72'(tx),   72'd0);
        check("hold.restart_done", 72'(done), 72'd0);
        start = 1'b0;
        capture("hold2", 1'b0, 1'b0);
        verify("hold2", vecs[0].exp);
        tick();
        check("hold.stop_busy", 72'(busy), 72'd0);

        // Reset in the middle of a message abandons it; next message is clean.
        start_msg(vecs[2].sgn, vecs[2].digs, 1'b0);
        repeat (100) tick();
        check("midrst.pre_busy", 72'(busy), 72'd1);
        reset = 1'b1;
        tick();
        check("midrst.tx",   72'(tx),   72'd1);
        check("midrst.busy", 72'(busy), 72'd0);
        check("midrst.done", 72'(done), 72'd0);
        reset = 1'b0;
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
            end
            check("midrst.quiet_bad_cycles", 72'(bad), 72'd0);
        end
        start_msg(vecs[0].sgn, vecs[0].digs, 1'b0);
        capture("postrst", 1'b0, 1'b0);
        verify("postrst", vecs[0].exp);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_uart_tx.md
# bcd_uart_tx

Serialises one signed 6-digit BCD reading (sign flag plus six 4-bit digits, as produced by the binary-to-BCD encoder stage) into a 9-character ASCII line on an 8N1 UART transmit pin. It sits directly downstream of the BCD encoder, in parallel with the seven-segment display path, and gives a host PC a logged copy of every displayed value. Each message is sent on a one-cycle start request; inputs are captured at acceptance, so the encoder may change freely during transmission.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to send one message; acted on only when busy=0.
- sign  in  1  1 = negative value.
- digit0 .. digit5  in  4 each  BCD digits; digit0 is the least significant, digit5 the most significant.
- tx  out  1  UART serial output; idle high.
- busy  out  1  high while a message is in flight.
- done  out  1  one-cycle pulse on message completion.

## Operation
- Message, in transmit order: sign char, digit5, digit4, digit3, digit2, digit1, digit0, CR (0x0D), LF (0x0A). Nine characters total.
- Sign char: 0x2D ('-') when sign=1, 0x20 (space) when sign=0.
- Digit char: 0x30 + d for d in 0..9; any d in 10..15 is sent as 0x3F ('?'). No leading-zero suppression.
- Snapshot: on accepted start, sign and all six digits are registered; later input changes do not affect the current message.
- Character framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Characters are sent back-to-back with no idle gap.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
  - IDLE -> START_BIT on start with busy=0. Character index is cleared to 0.
  - START_BIT -> DATA_BITS after CLKS_PER_BIT cycles. Bit index is cleared to 0.
  - DATA_BITS: advance the bit index every CLKS_PER_BIT cycles; -> STOP_BIT after bit 7.
  - STOP_BIT -> START_BIT (next character) after CLKS_PER_BIT cycles if char index < 8; otherwise -> IDLE with done pulsed.
- start while busy=1 is ignored, not queued.
- Counter widths: baud counter is clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1, then wraps. Bit index is 3 bits. Character index is 4 bits, 0..8.

## Timing
- Reset values: tx=1, busy=0, done=0, state=IDLE, all counters 0, snapshot registers 0.
- Reset asserted mid-message: on the next edge, tx=1, busy=0, done=0, and no further bits are sent. The truncated frame is not completed.
- start sampled high with busy=0 at edge N: at edge N+1, busy=1 and tx=0 (start bit begins).
- Each bit holds tx stable for exactly CLKS_PER_BIT cycles.
- Message length: busy stays high for exactly 90*CLKS_PER_BIT cycles.
- End of message: in the first cycle with busy=0, done=1 for that single cycle, tx=1.
- start asserted in that same done cycle is accepted, giving back-to-back messages with no idle bit time.
- done and busy are never high together.

## Structure
- Package bcd_uart_pkg holds:
  - ASCII constants: CHAR_MINUS, CHAR_SPACE, CHAR_ZERO, CHAR_ERR, CHAR_CR, CHAR_LF.
  - MSG_LEN = 9.
  - FSM state enum tx_state_t.
- Sub-module bcd_to_ascii: pure combinational, 4-bit digit in, 8-bit char out, includes the '?' mapping.
- The character multiplexer (char index -> byte) and the serialiser FSM both live in bcd_uart_tx.

## Test plan
All scenarios run with CLKS_PER_BIT=4.
- Reset then idle 50 cycles -> tx=1, busy=0, done=0 throughout.
- sign=1, digits 1,2,3,4,5,6 (digit5..digit0), start pulse -> bytes 2D 31 32 33 34 35 36 0D 0A decoded LSB-first. busy high for exactly 360 cycles, then a single done pulse.
- sign=0, all digits 0 -> bytes 20 30 30 30 30 30 30 0D 0A. Also change the digit inputs 20 cycles after start -> decoded bytes unchanged.
- digit0=4'hC, others 9 -> last digit char 3F, others 39.
- start held high continuously -> consecutive messages, each start bit beginning the cycle after done. Extra start pulses mid-message are not queued.
- Reset asserted at cycle 100 of a message -> next edge tx=1, busy=0. A subsequent start sends a complete, correct message.
